l1_dcache: RTL and testbench
============================

Name: l1_dcache

Overview:
- Two-way set-associative, write-back, write-allocate L1 data cache.
- Sits directly downstream of the CPU datapath ME stage.
- Services the datapath's line-wide request/response port (16-bit address, 128-bit line, 16-bit byte enables).
- On a miss it fetches from, or writes back to, the next memory level over a request/response line port.

Parameters:
- S_IDX, 3, log2 of set count (8 sets).
- LINE_BITS, 128, line width in bits (16 bytes); offset = 4 address bits, tag = 16 - S_IDX - 4 (9 bits default).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mem_address  input  16  CPU byte address; bits [3:0] ignored by the cache
- mem_req  input  1  CPU request valid, held high until mem_resp
- mem_we  input  1  1 = write, 0 = read; qualified by mem_req
- mem_byte_en  input  16  per-byte write enable within the line
- mem_wdata  input  128  CPU write line, pre-shifted to byte lanes
- mem_rdata  output  128  full cache line for the requested address
- mem_resp  output  1  one-cycle completion pulse
- pmem_address  output  16  line address to next level, bits [3:0] = 0
- pmem_read  output  1  line fill request, held until pmem_resp
- pmem_write  output  1  line writeback request, held until pmem_resp
- pmem_wdata  output  128  victim line being written back
- pmem_rdata  input  128  fill data, valid when pmem_resp = 1
- pmem_resp  input  1  next-level completion pulse

Behaviour:
- Storage per way: data[8] x 128, tag[8] x 9, valid[8], dirty[8]; one LRU bit per set (value = LRU way).
- Reset:
  - clears all valid, dirty and LRU bits; data and tag arrays are not cleared.
  - state -> COMPARE.
  - outputs: mem_resp = 0, pmem_read = 0, pmem_write = 0, pmem_address = 0, mem_rdata and pmem_wdata don't-care.
- Reset overrides everything, including mid-WRITEBACK/ALLOCATE: the request drops next cycle and any in-flight pmem_resp is ignored.
- Index = mem_address[S_IDX+3:4]; tag = mem_address[15:S_IDX+4].
- State COMPARE:
  - hit = valid & tag match in either way, evaluated combinationally from array reads.
  - mem_req & hit -> mem_resp = 1 in the same cycle; mem_rdata = hit way's line.
    - At the clock edge, LRU set to the other way.
    - If mem_we: bytes with mem_byte_en[i] = 1 are merged from mem_wdata and dirty is set. A byte_en of 0 still counts as a write hit.
  - mem_req & miss: victim = an invalid way if one exists (way 0 preferred), else the LRU way.
    - victim valid & dirty -> WRITEBACK; otherwise -> ALLOCATE.
  - mem_req = 0 -> stay; mem_resp = 0.
- State WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line.
  - On pmem_resp: clear victim dirty -> ALLOCATE.
- State ALLOCATE:
  - pmem_read = 1, pmem_address = {req tag, index, 4'b0}.
  - On pmem_resp: write pmem_rdata into the victim way, set tag and valid, clear dirty -> COMPARE.
  - The access then completes as a hit, one cycle after the fill.
- Hit latency: 0 cycles (same-cycle response).
- Clean-miss latency: fill latency + 1 cycle.
- Dirty-miss latency: writeback latency + fill latency + 1 cycle.
- mem_resp is never asserted outside COMPARE.
- pmem_read and pmem_write are never asserted together.
- The request's address, we, byte_en and wdata must be stable while mem_req = 1 until mem_resp. Changing them mid-miss is illegal.
- mem_req still high in the cycle after mem_resp is a new request.
- No second outstanding request is accepted.
- pmem_resp in COMPARE is ignored.

Test Plan:
- Cold read 0x1234 after reset; next level returns a fill line L = 0x00112233_44556677_8899AABB_CCDDEEFF after 5 cycles -> one pmem_read at 0x1230, mem_resp exactly 1 cycle after the fill, mem_rdata = L, no pmem_write.
- Read 0x123A immediately after -> mem_resp in the same cycle, no pmem activity, same line L.
- Write 0x1234 with byte_en 0x0030 and wdata bytes 4,5 = 0xBEEF -> same-cycle resp; re-read shows only bytes 4,5 changed; dirty = 1.
- Same index, fill tags A (0x1230) and B (0x3230), touch A, then access tag C (0x5230) -> B is evicted. If B is dirty: pmem_write at 0x3230 with B's data precedes pmem_read at 0x5230.
- Dirty eviction of A by back-to-back misses -> writeback data equals the merged line; dirty is cleared on the new line.
- Assert reset during ALLOCATE, then pulse pmem_resp -> pmem_read = 0 the next cycle, no array update, all lines miss afterward.

Source files
------------

// File: rtl/l1_dcache.sv
// Two-way set-associative, write-back, write-allocate L1 data cache with a
// same-cycle hit path and a line-wide refill/writeback port to the next level.
module l1_dcache #(
  parameter int S_IDX     = 3,
  parameter int LINE_BITS = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            mem_address,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [LINE_BITS/8-1:0] mem_byte_en,
  input  logic [LINE_BITS-1:0]   mem_wdata,
  output logic [LINE_BITS-1:0]   mem_rdata,
  output logic                   mem_resp,
  output logic [15:0]            pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [LINE_BITS-1:0]   pmem_wdata,
  input  logic [LINE_BITS-1:0]   pmem_rdata,
  input  logic                   pmem_resp
);

  localparam int SETS   = 1 << S_IDX;
  localparam int TAG_W  = 16 - S_IDX - 4;
  localparam int NBYTES = LINE_BITS / 8;

  typedef enum logic [1:0] {ST_COMPARE, ST_WRITEBACK, ST_ALLOCATE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LINE_BITS-1:0] r_data [2][SETS];
  logic [TAG_W-1:0]     r_tag  [2][SETS];
  logic [SETS-1:0]      r_valid [2];
  logic [SETS-1:0]      r_dirty [2];
  logic [SETS-1:0]      r_lru;
  logic                 r_victim;

  logic [S_IDX-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit0;
  logic                 w_hit1;
  logic                 w_hit;
  logic                 w_hit_way;
  logic                 w_victim;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [LINE_BITS-1:0] w_merged;
  logic                 w_access_hit;
  logic                 w_miss;
  logic                 w_wb_done;
  logic                 w_fill_done;
  logic                 w_unused;

  assign w_idx    = mem_address[S_IDX+3:4];
  assign w_tag    = mem_address[15:S_IDX+4];
  assign w_unused = ^mem_address[3:0];

  assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_way  = w_hit1;
  assign w_hit_line = w_hit_way ? r_data[1][w_idx] : r_data[0][w_idx];

  // Prefer an empty way (way 0 first); only a full set consults the LRU bit.
  assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                    !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

  assign w_access_hit = (r_state == ST_COMPARE) && mem_req && w_hit;
  assign w_miss       = (r_state == ST_COMPARE) && mem_req && !w_hit;
  assign w_wb_done    = (r_state == ST_WRITEBACK) && pmem_resp;
  assign w_fill_done  = (r_state == ST_ALLOCATE) && pmem_resp;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign w_merged[gi*8 +: 8] = mem_byte_en[gi] ? mem_wdata[gi*8 +: 8]
                                                   : w_hit_line[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    mem_rdata    = w_hit_line;
    pmem_wdata   = r_data[r_victim][w_idx];
    case (r_state)
      ST_COMPARE: begin
        if (mem_req) begin
          if (w_hit) begin
            mem_resp = 1'b1;
          end else if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
            w_state_next = ST_WRITEBACK;
          end else begin
            w_state_next = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_victim][w_idx], w_idx, 4'b0000};
        if (pmem_resp) begin
          w_state_next = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {w_tag, w_idx, 4'b0000};
        if (pmem_resp) begin
          w_state_next = ST_COMPARE;
        end
      end
      default: w_state_next = ST_COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_COMPARE;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
      r_victim   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_access_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (mem_we) begin
          r_dirty[w_hit_way][w_idx] <= 1'b1;
        end
      end
      if (w_miss) begin
        r_victim <= w_victim;
      end
      if (w_wb_done) begin
        r_dirty[r_victim][w_idx] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[r_victim][w_idx] <= 1'b1;
        r_dirty[r_victim][w_idx] <= 1'b0;
      end
    end
  end

  // Line storage is never cleared; reset only blocks updates in its cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_access_hit && mem_we) begin
        r_data[w_hit_way][w_idx] <= w_merged;
      end
      if (w_fill_done) begin
        r_data[r_victim][w_idx] <= pmem_rdata;
        r_tag[r_victim][w_idx]  <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: flat memory model plus LRU residency list predicts
// latency, line data and next-level traffic for every access.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_byte_en;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic         rsp_resp = 1'b0;
  logic [127:0] rsp_data = '0;
  logic         inj_resp = 1'b0;
  logic [127:0] inj_data = '0;
  assign pmem_resp  = rsp_resp | inj_resp;
  assign pmem_rdata = inj_resp ? inj_data : rsp_data;

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  localparam logic [127:0] LINE_L  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_LM = 128'h00112233_44556677_8899BEEF_CCDDEEFF;
  localparam logic [127:0] WD_BEEF = 128'h00000000_00000000_0000BEEF_00000000;
  localparam logic [127:0] WD_B    = 128'hB0B00001_B0B00001_B0B00001_B0B00001;

  typedef struct packed {logic wr; logic [15:0] a; logic [127:0] d;} ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_lat = 5;
  bit rsp_en = 1'b1;

  ev_t          pm_log[$];
  logic [127:0] nl_mem   [logic [15:0]];
  logic [127:0] arch_mem [logic [15:0]];
  bit           dirty_m  [logic [15:0]];
  logic [15:0]  resident[$];

  logic [15:0] t_a  [11] = '{16'h0400, 16'h0404, 16'h0800, 16'h0C00, 16'h0400, 16'h0C08,
                             16'h0800, 16'h1070, 16'hFFF0, 16'h2070, 16'h3070};
  bit          t_we [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] t_be [11] = '{16'h0000, 16'h000F, 16'h0000, 16'h8001, 16'h0000, 16'h0000,
                             16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
  int          t_lat[11] = '{1, 2, 3, 1, 4, 2, 1, 3, 2, 1, 6};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] init_line(input logic [15:0] la);
    if (la == 16'h1230) return LINE_L;
    return {la, ~la, la ^ 16'h5A5A, la + 16'h0101, ~la ^ 16'h00FF, la, 16'hC3C3, la ^ 16'hFFF0};
  endfunction

  function automatic logic [127:0] nl_line(input logic [15:0] la);
    if (nl_mem.exists(la)) return nl_mem[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] arch_line(input logic [15:0] la);
    if (arch_mem.exists(la)) return arch_mem[la];
    return nl_line(la);
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] wd,
                                         input logic [15:0] be);
    logic [127:0] r;
    r = old;
    for (int i = 0; i < 16; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic we, input logic [15:0] be,
                        input logic [127:0] wd, output logic [127:0] rd);
    logic [15:0] la;
    logic [15:0] v;
    ev_t         exp_q[$];
    ev_t         e;
    int          n, vi, hi, exp_lat, start, lat;
    bit          wb, done;
    la = a & 16'hFFF0;
    hi = -1; n = 0; vi = -1; wb = 1'b0;
    for (int i = 0; i < resident.size(); i++) if (resident[i] == la) hi = i;
    if (hi >= 0) begin
      resident.delete(hi);
      resident.push_back(la);
    end else begin
      for (int i = 0; i < resident.size(); i++) begin
        if (resident[i][6:4] == la[6:4]) begin
          n++;
          if (vi < 0) vi = i;
        end
      end
      if (n >= 2) begin
        v = resident[vi];
        resident.delete(vi);
        if (dirty_m.exists(v)) begin
          e.wr = 1'b1; e.a = v; e.d = arch_line(v);
          exp_q.push_back(e);
          dirty_m.delete(v);
          wb = 1'b1;
        end
      end
      e.wr = 1'b0; e.a = la; e.d = arch_line(la);
      exp_q.push_back(e);
      resident.push_back(la);
    end
    if (we) dirty_m[la] = 1'b1;
    exp_lat = (hi >= 0) ? 0 : (wb ? 2 * rsp_lat + 3 : rsp_lat + 2);

    pm_log.delete();
    mem_address = a; mem_we = we; mem_byte_en = be; mem_wdata = wd; mem_req = 1'b1;
    start = cyc; done = 1'b0; rd = '0; lat = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (mem_resp) begin
        done = 1'b1;
        lat = cyc - start;
        rd = mem_rdata;
      end
    end
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    if (we) arch_mem[la] = merge(arch_line(la), wd, be);

    check($sformatf("latency_%h", a), lat, exp_lat);
    check($sformatf("pmem_count_%h", a), pm_log.size(), exp_q.size());
    for (int i = 0; i < pm_log.size() && i < exp_q.size(); i++) begin
      check($sformatf("pmem_kind_%h_%0d", a, i), pm_log[i].wr, exp_q[i].wr);
      check($sformatf("pmem_addr_%h_%0d", a, i), pm_log[i].a, exp_q[i].a);
      check($sformatf("pmem_data_%h_%0d", a, i), pm_log[i].d, exp_q[i].d);
    end
    $display("access a=%h we=%b be=%h lat=%0d pmem_ops=%0d rdata=%h", a, we, be, lat,
             pm_log.size(), rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd;
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_address = '0;
    mem_byte_en = '0; mem_wdata = '0;

    fork
      begin : responder
        ev_t e;
        forever begin
          @(negedge clk);
          if (rsp_en && !reset && (pmem_read || pmem_write)) begin
            e.wr = pmem_write; e.a = pmem_address; e.d = pmem_wdata;
            repeat (rsp_lat) @(posedge clk);
            #1;
            if (e.wr) nl_mem[e.a] = e.d;
            else begin
              e.d = nl_line(e.a);
              rsp_data = e.d;
            end
            rsp_resp = 1'b1;
            @(posedge clk);
            #1;
            rsp_resp = 1'b0;
            rsp_data = {4{$urandom}};
            pm_log.push_back(e);
          end
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (!reset) begin
            check("pmem_read_write_exclusive", pmem_read && pmem_write, 1'b0);
            if (mem_resp) begin
              check("resp_with_req", mem_req, 1'b1);
              check("resp_rdata", mem_rdata, arch_line(mem_address & 16'hFFF0));
            end
            if (pmem_read || pmem_write) check("pmem_addr_aligned", pmem_address[3:0], 4'h0);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mem_resp", mem_resp, 1'b0);
    check("reset_pmem_read", pmem_read, 1'b0);
    check("reset_pmem_write", pmem_write, 1'b0);
    check("reset_pmem_address", pmem_address, 16'h0000);
    @(posedge clk);
    #1;

    rsp_lat = 5;
    access(16'h1234, 1'b0, 16'h0000, '0, rd);
    check("cold_rdata", rd, LINE_L);
    if (pm_log.size() > 0) check("cold_fill_addr", pm_log[0].a, 16'h1230);
    access(16'h123A, 1'b0, 16'h0000, '0, rd);
    check("hit_rdata", rd, LINE_L);
    access(16'h1234, 1'b1, 16'h0030, WD_BEEF, rd);
    check("write_hit_old_line", rd, LINE_L);
    access(16'h1234, 1'b0, 16'h0000, '0, rd);
    check("merged_rdata", rd, LINE_LM);

    access(16'h3230, 1'b0, 16'h0000, '0, rd);
    access(16'h3238, 1'b1, 16'hFFFF, WD_B, rd);
    access(16'h1230, 1'b0, 16'h0000, '0, rd);
    access(16'h5230, 1'b0, 16'h0000, '0, rd);
    if (pm_log.size() > 0) begin
      check("evict_b_addr", pm_log[0].a, 16'h3230);
      check("evict_b_data", pm_log[0].d, WD_B);
    end
    access(16'h7230, 1'b0, 16'h0000, '0, rd);
    if (pm_log.size() > 0) check("evict_a_data", pm_log[0].d, LINE_LM);
    access(16'h9230, 1'b0, 16'h0000, '0, rd);
    access(16'hB230, 1'b0, 16'h0000, '0, rd);
    check("clean_evict_single_op", pm_log.size(), 1);
    access(16'h1234, 1'b0, 16'h0000, '0, rd);
    check("refetch_merged", rd, LINE_LM);

    for (int i = 0; i < 11; i++) begin
      rsp_lat = t_lat[i];
      access(t_a[i], t_we[i], t_be[i], {4{32'hDEAD0000 | i}}, rd);
    end

    rsp_lat = 5;
    rsp_en = 1'b0;
    mem_address = 16'h4454; mem_we = 1'b0; mem_byte_en = '0; mem_req = 1'b1;
    @(negedge clk);
    check("rst_test_miss_no_resp", mem_resp, 1'b0);
    @(negedge clk);
    check("rst_test_alloc_read", pmem_read, 1'b1);
    check("rst_test_alloc_addr", pmem_address, 16'h4450);
    @(posedge clk);
    #1;
    reset = 1'b1; mem_req = 1'b0; inj_resp = 1'b1; inj_data = {4{32'hDEADBEEF}};
    @(posedge clk);
    #1;
    reset = 1'b0; inj_resp = 1'b0;
    @(negedge clk);
    check("rst_test_read_dropped", pmem_read, 1'b0);
    check("rst_test_write_idle", pmem_write, 1'b0);
    check("rst_test_addr_zero", pmem_address, 16'h0000);
    resident.delete();
    dirty_m.delete();
    arch_mem.delete();
    rsp_en = 1'b1;
    @(posedge clk);
    #1;
    access(16'h1234, 1'b0, 16'h0000, '0, rd);
    check("post_reset_rdata", rd, LINE_LM);
    access(16'h4454, 1'b0, 16'h0000, '0, rd);
    check("post_reset_fill_data", rd, init_line(16'h4450));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
